// File: rtl/coprocessor0_params.sv
// Types exported by CP0 to the pipeline stages.
package coprocessor0_params;

  typedef struct packed {
    logic [31:0] exception_address;
  } CP0ToIFData;

endpackage

// File: rtl/cpu_core_params.sv
// Core-wide constants and the IF->ID payload type.
package cpu_core_params;

  localparam logic [4:0]  EXCCODE_ADEL             = 5'h04;
  localparam logic [31:0] RESET_VECTOR_DEFAULT     = 32'hBFC0_0000;
  localparam logic [31:0] EXCEPTION_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        exception;
    logic [4:0]  exception_code;
  } IFToIDData;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-side bus: instruction SRAM request/response plus the IF->ID handshake.
// Handshake: IF presents if_to_id_valid/if_to_id_data; a transfer happens on a rising
// clock edge where both if_to_id_valid and id_allow_in are high.
interface instruction_fetch_stage_if;
  import cpu_core_params::*;

  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        if_to_id_valid;
  IFToIDData   if_to_id_data;
  logic        id_allow_in;

  modport master (
    output inst_sram_en,
    output inst_sram_addr,
    input  inst_sram_rdata,
    output if_to_id_valid,
    output if_to_id_data,
    input  id_allow_in
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_addr,
    output inst_sram_rdata,
    input  if_to_id_valid,
    input  if_to_id_data,
    output id_allow_in
  );
endinterface

// File: rtl/fetch_instruction_buffer.sv
// Holds the SRAM read data while ID stalls, because the SRAM output only lasts one cycle.
module fetch_instruction_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  input  logic        advance,
  input  logic        flush,
  input  logic [31:0] rdata,
  output logic [31:0] instruction_out
);

  logic [31:0] instr_buffer;
  logic        buffer_valid;

  always_ff @(posedge clock) begin
    if (reset || flush || advance) begin
      buffer_valid <= 1'b0;
      instr_buffer <= '0;
    end else if (capture && !buffer_valid) begin
      buffer_valid <= 1'b1;
      instr_buffer <= rdata;
    end
  end

  assign instruction_out = buffer_valid ? instr_buffer : rdata;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, issues instruction SRAM reads, and redirects on branches
// (after the delay slot), exception flushes and ERET.
module instruction_fetch_stage
  import cpu_core_params::*;
  import coprocessor0_params::*;
#(
  parameter logic [31:0] RESET_VECTOR     = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] EXCEPTION_VECTOR = EXCEPTION_VECTOR_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  CP0ToIFData                 cp0_to_if_data_bus,
  input  logic                       exception_flush,
  input  logic                       eret_flush,
  input  logic                       branch_valid,
  input  logic [31:0]                branch_target,
  instruction_fetch_stage_if.master  fetch_bus,
  output logic [1:0]                 branch_fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    READY   = 2'd2
  } branch_state_t;

  branch_state_t state_q, state_d;
  logic [31:0]   target_q, target_d;
  logic [31:0]   if_pc, next_pc, seq_pc, instruction;
  logic          if_valid, if_exception;
  logic          flush, if_allow_in, issue, aligned;
  IFToIDData     out_data;

  assign flush       = exception_flush | eret_flush;
  assign if_allow_in = !if_valid | fetch_bus.id_allow_in | flush;
  assign issue       = if_allow_in & !reset;
  assign seq_pc      = if_pc + 32'd4;

  always_comb begin
    next_pc = seq_pc;
    if (exception_flush)
      next_pc = EXCEPTION_VECTOR;
    else if (eret_flush)
      next_pc = cp0_to_if_data_bus.exception_address;
    else if (state_q == READY)
      next_pc = target_q;
    else if (branch_valid && state_q == IDLE && if_valid)
      next_pc = branch_target;
  end

  assign aligned                  = (next_pc[1:0] == 2'b00);
  assign fetch_bus.inst_sram_en   = issue & aligned;
  assign fetch_bus.inst_sram_addr = next_pc;

  // The target is latched whenever it cannot be issued in the cycle the branch resolves.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (branch_valid && !if_valid) begin
            state_d  = WAIT_DS;
            target_d = branch_target;
          end else if (branch_valid && !if_allow_in) begin
            state_d  = READY;
            target_d = branch_target;
          end
        end
        WAIT_DS: if (issue) state_d = READY;
        READY:   if (issue) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if_pc        <= RESET_VECTOR - 32'd4;
      if_valid     <= 1'b0;
      if_exception <= 1'b0;
      state_q      <= IDLE;
      target_q     <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if (issue) begin
        if_pc        <= next_pc;
        if_valid     <= 1'b1;
        if_exception <= !aligned;
      end
    end
  end

  fetch_instruction_buffer u_buffer (
    .clock           (clock),
    .reset           (reset),
    .capture         (if_valid & !fetch_bus.id_allow_in & !flush),
    .advance         (issue),
    .flush           (flush),
    .rdata           (fetch_bus.inst_sram_rdata),
    .instruction_out (instruction)
  );

  // A misaligned fetch never reached the SRAM, so its instruction word is forced to zero.
  always_comb begin
    out_data = '0;
    if (if_valid) begin
      out_data.pc             = if_pc;
      out_data.exception      = if_exception;
      out_data.exception_code = if_exception ? EXCCODE_ADEL : 5'h00;
      out_data.instruction    = if_exception ? 32'h0 : instruction;
    end
  end

  assign fetch_bus.if_to_id_valid = if_valid;
  assign fetch_bus.if_to_id_data  = out_data;
  assign branch_fsm_state         = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a 1-cycle-latency SRAM model.
module tb_instruction_fetch_stage;
  import cpu_core_params::*;
  import coprocessor0_params::*;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd2;

  logic        clock;
  logic        reset;
  CP0ToIFData  cp0_bus;
  logic        exception_flush;
  logic        eret_flush;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [1:0]  branch_fsm_state;
  logic        garbage;

  int vectors_applied = 0;
  int miscompares     = 0;
  logic [31:0] exp_q[$];

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage dut (
    .clock              (clock),
    .reset              (reset),
    .cp0_to_if_data_bus (cp0_bus),
    .exception_flush    (exception_flush),
    .eret_flush         (eret_flush),
    .branch_valid       (branch_valid),
    .branch_target      (branch_target),
    .fetch_bus          (bus.master),
    .branch_fsm_state   (branch_fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return addr ^ 32'h1234_5678;
  endfunction

  // SRAM: data appears the cycle after the request; garbage mode scrambles idle cycles
  always @(posedge clock) begin
    if (bus.inst_sram_en)
      bus.inst_sram_rdata <= inst_of(bus.inst_sram_addr);
    else if (garbage)
      bus.inst_sram_rdata <= $urandom_range(32'hFFFF, 0) ^ 32'hA5A5_0000;
  end

  function automatic IFToIDData exp_data(input logic [31:0] pc, input logic [31:0] inst,
                                         input logic exc, input logic [4:0] code);
    IFToIDData d;
    d.pc = pc;
    d.instruction = inst;
    d.exception = exc;
    d.exception_code = code;
    return d;
  endfunction

  task automatic check_vec(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_fetched(input string tag, input logic [31:0] pc);
    check_vec({tag, "_valid"}, bus.if_to_id_valid, 1'b1);
    check_vec({tag, "_data"}, bus.if_to_id_data, exp_data(pc, inst_of(pc), 1'b0, 5'h00));
  endtask

  initial begin
    reset = 1'b1;
    cp0_bus = '0;
    exception_flush = 1'b0;
    eret_flush = 1'b0;
    branch_valid = 1'b0;
    branch_target = '0;
    garbage = 1'b0;
    bus.id_allow_in = 1'b1;
    bus.inst_sram_rdata = '0;

    repeat (2) @(negedge clock);
    #1;
    check_vec("rst_en", bus.inst_sram_en, 1'b0);
    check_vec("rst_valid", bus.if_to_id_valid, 1'b0);
    check_vec("rst_data", bus.if_to_id_data, 70'h0);
    check_vec("rst_fsm", branch_fsm_state, ST_IDLE);

    // sequential fetch out of reset
    reset = 1'b0;
    exp_q = {32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec("seq_en", bus.inst_sram_en, 1'b1);
      check_vec("seq_addr", bus.inst_sram_addr, exp_q.pop_front());
      if (i > 0) check_fetched("seq", 32'hBFC0_0000 + 32'(4 * (i - 1)));
      @(negedge clock);
    end

    // stall with scrambled SRAM output: buffer must hold BFC00008
    bus.id_allow_in = 1'b0;
    garbage = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec("stall_en", bus.inst_sram_en, 1'b0);
      check_fetched("stall", 32'hBFC0_0008);
      @(negedge clock);
    end
    bus.id_allow_in = 1'b1;
    garbage = 1'b0;
    #1;
    check_vec("release_en", bus.inst_sram_en, 1'b1);
    check_vec("release_addr", bus.inst_sram_addr, 32'hBFC0_000C);
    check_fetched("release_hold", 32'hBFC0_0008);
    @(negedge clock);
    #1;
    check_fetched("release_next", 32'hBFC0_000C);
    check_vec("release_addr2", bus.inst_sram_addr, 32'hBFC0_0010);

    // branch while IF holds the delay slot
    branch_valid = 1'b1;
    branch_target = 32'hBFC0_0100;
    #1;
    check_vec("br_addr", bus.inst_sram_addr, 32'hBFC0_0100);
    check_vec("br_en", bus.inst_sram_en, 1'b1);
    @(negedge clock);
    branch_valid = 1'b0;
    #1;
    check_fetched("br_target", 32'hBFC0_0100);
    check_vec("br_fsm", branch_fsm_state, ST_IDLE);
    check_vec("br_next", bus.inst_sram_addr, 32'hBFC0_0104);

    // branch during a stall: target latched, issued on release
    branch_valid = 1'b1;
    branch_target = 32'hBFC0_0200;
    bus.id_allow_in = 1'b0;
    #1;
    check_vec("brs_en", bus.inst_sram_en, 1'b0);
    @(negedge clock);
    branch_valid = 1'b0;
    #1;
    check_vec("brs_fsm", branch_fsm_state, ST_READY);
    check_vec("brs_en2", bus.inst_sram_en, 1'b0);
    check_fetched("brs_hold", 32'hBFC0_0100);
    @(negedge clock);
    bus.id_allow_in = 1'b1;
    #1;
    check_vec("brs_addr", bus.inst_sram_addr, 32'hBFC0_0200);
    check_vec("brs_en3", bus.inst_sram_en, 1'b1);
    @(negedge clock);
    #1;
    check_fetched("brs_target", 32'hBFC0_0200);
    check_vec("brs_fsm2", branch_fsm_state, ST_IDLE);

    // exception flush beats a simultaneous branch
    exception_flush = 1'b1;
    branch_valid = 1'b1;
    branch_target = 32'hBFC0_0300;
    #1;
    check_vec("exc_addr", bus.inst_sram_addr, 32'hBFC0_0380);
    check_vec("exc_en", bus.inst_sram_en, 1'b1);
    @(negedge clock);
    exception_flush = 1'b0;
    branch_valid = 1'b0;
    #1;
    check_vec("exc_fsm", branch_fsm_state, ST_IDLE);
    check_fetched("exc_vec", 32'hBFC0_0380);
    check_vec("exc_next", bus.inst_sram_addr, 32'hBFC0_0384);

    // ERET to aligned EPC
    eret_flush = 1'b1;
    cp0_bus.exception_address = 32'hBFC0_0010;
    #1;
    check_vec("eret_addr", bus.inst_sram_addr, 32'hBFC0_0010);
    check_vec("eret_en", bus.inst_sram_en, 1'b1);
    @(negedge clock);
    eret_flush = 1'b0;
    #1;
    check_fetched("eret_epc", 32'hBFC0_0010);

    // ERET to misaligned EPC: AdEL, fetch keeps going at pc+4 without SRAM requests
    eret_flush = 1'b1;
    cp0_bus.exception_address = 32'hBFC0_0012;
    #1;
    check_vec("adel_en", bus.inst_sram_en, 1'b0);
    @(negedge clock);
    eret_flush = 1'b0;
    #1;
    check_vec("adel_data", bus.if_to_id_data, exp_data(32'hBFC0_0012, 32'h0, 1'b1, 5'h04));
    check_vec("adel_valid", bus.if_to_id_valid, 1'b1);
    check_vec("adel_en2", bus.inst_sram_en, 1'b0);
    @(negedge clock);
    #1;
    check_vec("adel_next", bus.if_to_id_data, exp_data(32'hBFC0_0016, 32'h0, 1'b1, 5'h04));
    exception_flush = 1'b1;
    #1;
    check_vec("adel_flush_addr", bus.inst_sram_addr, 32'hBFC0_0380);
    check_vec("adel_flush_en", bus.inst_sram_en, 1'b1);
    @(negedge clock);
    exception_flush = 1'b0;
    #1;
    check_fetched("adel_recover", 32'hBFC0_0380);

    // reset during a stall with the buffer full and a latched branch
    bus.id_allow_in = 1'b0;
    branch_valid = 1'b1;
    branch_target = 32'hBFC0_0500;
    @(negedge clock);
    branch_valid = 1'b0;
    #1;
    check_vec("mrst_fsm_pre", branch_fsm_state, ST_READY);
    reset = 1'b1;
    #1;
    check_vec("mrst_en", bus.inst_sram_en, 1'b0);
    @(negedge clock);
    #1;
    check_vec("mrst_valid", bus.if_to_id_valid, 1'b0);
    check_vec("mrst_fsm", branch_fsm_state, ST_IDLE);
    check_vec("mrst_data", bus.if_to_id_data, 70'h0);
    reset = 1'b0;
    bus.id_allow_in = 1'b1;
    #1;
    check_vec("mrst_addr", bus.inst_sram_addr, 32'hBFC0_0000);
    check_vec("mrst_en2", bus.inst_sram_en, 1'b1);
    @(negedge clock);
    #1;
    check_fetched("mrst_first", 32'hBFC0_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
